// File: rtl/fifo_multi_out_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_multi_out_if
// Brief    : Byte-in / lookahead-window-out handshake bundle for fifo_multi_out.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_multi_out_if #(
    parameter int FIFO_SIZE     = 128,
    parameter int MAX_BYTES_OUT = 16
);
    localparam int CNT_WIDTH = $clog2(MAX_BYTES_OUT + 1);
    localparam int OCC_WIDTH = $clog2(FIFO_SIZE + 1);

    logic [7:0]           data_in;
    logic                 wr_en_in;
    logic                 rd_en_in;
    logic [CNT_WIDTH-1:0] num_bytes_in;
    logic [7:0]           data_out [MAX_BYTES_OUT];
    logic [CNT_WIDTH-1:0] valid_bytes_out;
    logic                 fifo_empty_out;
    logic                 fifo_full_out;
    logic [OCC_WIDTH-1:0] occupancy;
    logic                 error_out;

    modport master (
        output data_in, wr_en_in, rd_en_in, num_bytes_in,
        input  data_out, valid_bytes_out, fifo_empty_out, fifo_full_out,
               occupancy, error_out
    );

    modport slave (
        input  data_in, wr_en_in, rd_en_in, num_bytes_in,
        output data_out, valid_bytes_out, fifo_empty_out, fifo_full_out,
               occupancy, error_out
    );
endinterface
`default_nettype wire

// File: rtl/fifo_multi_out.sv
`default_nettype none
// ============================================================================
// Module   : fifo_multi_out
// Brief    : Byte-wide-in circular FIFO exposing a MAX_BYTES_OUT lookahead
//            window; consumer retires 1..MAX_BYTES_OUT bytes per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_multi_out #(
    parameter int FIFO_SIZE     = 128,
    parameter int MAX_BYTES_OUT = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fifo_multi_out_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(FIFO_SIZE);
    localparam int CNT_WIDTH  = $clog2(MAX_BYTES_OUT + 1);
    localparam int OCC_WIDTH  = $clog2(FIFO_SIZE + 1);

    localparam logic [OCC_WIDTH-1:0] c_FULL_OCC = OCC_WIDTH'(FIFO_SIZE);
    localparam logic [OCC_WIDTH-1:0] c_WIN_OCC  = OCC_WIDTH'(MAX_BYTES_OUT);
    localparam logic [CNT_WIDTH-1:0] c_WIN_CNT  = CNT_WIDTH'(MAX_BYTES_OUT);

    logic [7:0]            r_buf [FIFO_SIZE];
    logic [ADDR_WIDTH-1:0] r_front;
    logic [ADDR_WIDTH-1:0] r_back;
    logic [OCC_WIDTH-1:0]  r_occ;
    logic                  r_err;

    logic [CNT_WIDTH-1:0]  w_valid;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [OCC_WIDTH-1:0]  w_occ_nxt;

    assign w_valid  = (r_occ >= c_WIN_OCC) ? c_WIN_CNT : r_occ[CNT_WIDTH-1:0];
    assign w_full   = (r_occ == c_FULL_OCC);
    assign w_rd_acc = bus.rd_en_in && (bus.num_bytes_in != '0)
                      && (bus.num_bytes_in <= w_valid);
    // A full FIFO still takes a byte when a read frees space in the same cycle.
    assign w_wr_acc = bus.wr_en_in && (!w_full || w_rd_acc);

    assign w_occ_nxt = r_occ + OCC_WIDTH'(w_wr_acc)
                     - (w_rd_acc ? OCC_WIDTH'(bus.num_bytes_in) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_front <= '0;
            r_back  <= '0;
            r_occ   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_back <= r_back + 1'b1;
            end
            if (w_rd_acc) begin
                r_front <= r_front + ADDR_WIDTH'(bus.num_bytes_in);
            end
            r_occ <= w_occ_nxt;
            if ((bus.rd_en_in && !w_rd_acc) || (bus.wr_en_in && !w_wr_acc)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the occupancy mask hides stale bytes.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_buf[r_back] <= bus.data_in;
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_BYTES_OUT; gi++) begin : g_window
            logic [ADDR_WIDTH-1:0] w_idx;
            assign w_idx = r_front + ADDR_WIDTH'(gi);
            assign bus.data_out[gi] = (CNT_WIDTH'(gi) < w_valid) ? r_buf[w_idx] : 8'h00;
        end
    endgenerate

    assign bus.valid_bytes_out = w_valid;
    assign bus.fifo_empty_out  = (r_occ == '0);
    assign bus.fifo_full_out   = w_full;
    assign bus.occupancy       = r_occ;
    assign bus.error_out       = r_err;

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset) r_occ <= c_FULL_OCC);
    a_flags: assert property (@(posedge clk) disable iff (!reset)
        !(bus.fifo_empty_out && bus.fifo_full_out));

endmodule
`default_nettype wire

// File: tb/tb_fifo_multi_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_multi_out
// Brief    : Directed, table-driven self-checking bench for fifo_multi_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_multi_out;
    localparam int FIFO_SIZE     = 128;
    localparam int MAX_BYTES_OUT = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fifo_multi_out_if #(.FIFO_SIZE(FIFO_SIZE), .MAX_BYTES_OUT(MAX_BYTES_OUT)) u_if ();

    fifo_multi_out #(.FIFO_SIZE(FIFO_SIZE), .MAX_BYTES_OUT(MAX_BYTES_OUT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic [4:0] num;
        int         e_valid;
        int         e_occ;
        int         e_d0;
        int         e_d1;
        int         e_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge and are sampled by the next edge.
    task automatic step(input logic we, input logic [7:0] d, input logic re, input logic [4:0] n);
        u_if.wr_en_in     = we;
        u_if.data_in      = d;
        u_if.rd_en_in     = re;
        u_if.num_bytes_in = n;
        @(posedge clk);
        #1;
        u_if.wr_en_in     = 1'b0;
        u_if.rd_en_in     = 1'b0;
        u_if.num_bytes_in = '0;
        u_if.data_in      = 8'h00;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_occ"},   int'(u_if.occupancy), 0);
        chk({tag, "_valid"}, int'(u_if.valid_bytes_out), 0);
        chk({tag, "_empty"}, int'(u_if.fifo_empty_out), 1);
        chk({tag, "_full"},  int'(u_if.fifo_full_out), 0);
        chk({tag, "_err"},   int'(u_if.error_out), 0);
        for (int i = 0; i < MAX_BYTES_OUT; i++) begin
            chk($sformatf("%s_d%0d", tag, i), int'(u_if.data_out[i]), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        u_if.wr_en_in     = 1'b0;
        u_if.rd_en_in     = 1'b0;
        u_if.num_bytes_in = '0;
        u_if.data_in      = 8'h00;

        //          wr   din    rd   num  valid occ d0     d1     err
        vecs[0] = '{1'b1, 8'h01, 1'b0, 5'd0, 1, 1, 8'h01, 8'h00, 0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 5'd0, 2, 2, 8'h01, 8'h02, 0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 5'd0, 3, 3, 8'h01, 8'h02, 0};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 5'd0, 4, 4, 8'h01, 8'h02, 0};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 5'd0, 5, 5, 8'h01, 8'h02, 0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd3, 2, 2, 8'h04, 8'h05, 0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd3, 2, 2, 8'h04, 8'h05, 1};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic write / window / consume / over-read
        for (int v = 0; v < 7; v++) begin
            step(vecs[v].wr, vecs[v].din, vecs[v].rd, vecs[v].num);
            chk($sformatf("v%0d_valid", v), int'(u_if.valid_bytes_out), vecs[v].e_valid);
            chk($sformatf("v%0d_occ", v),   int'(u_if.occupancy),       vecs[v].e_occ);
            chk($sformatf("v%0d_d0", v),    int'(u_if.data_out[0]),     vecs[v].e_d0);
            chk($sformatf("v%0d_d1", v),    int'(u_if.data_out[1]),     vecs[v].e_d1);
            chk($sformatf("v%0d_err", v),   int'(u_if.error_out),       vecs[v].e_err);
            if (v == 4) begin
                for (int i = 0; i < MAX_BYTES_OUT; i++) begin
                    chk($sformatf("s1_d%0d", i), int'(u_if.data_out[i]), (i < 5) ? i + 1 : 0);
                end
            end
        end
        chk("s2_d2_masked", int'(u_if.data_out[2]), 0);

        // Full FIFO: rejected write, then write paired with read
        do_reset();
        for (int i = 0; i < FIFO_SIZE; i++) step(1'b1, 8'(i), 1'b0, 5'd0);
        chk("s3_full",  int'(u_if.fifo_full_out), 1);
        chk("s3_valid", int'(u_if.valid_bytes_out), 16);
        chk("s3_occ",   int'(u_if.occupancy), 128);
        chk("s3_err0",  int'(u_if.error_out), 0);
        chk("s3_d15",   int'(u_if.data_out[15]), 8'h0F);
        step(1'b1, 8'hAA, 1'b0, 5'd0);
        chk("s3_drop_occ", int'(u_if.occupancy), 128);
        chk("s3_drop_err", int'(u_if.error_out), 1);
        chk("s3_drop_d0",  int'(u_if.data_out[0]), 8'h00);
        step(1'b1, 8'hBB, 1'b1, 5'd1);
        chk("s3_rw_occ",  int'(u_if.occupancy), 128);
        chk("s3_rw_full", int'(u_if.fifo_full_out), 1);
        chk("s3_rw_d0",   int'(u_if.data_out[0]), 8'h01);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 5'd16);
        chk("s3_tail_occ", int'(u_if.occupancy), 16);
        chk("s3_tail_d0",  int'(u_if.data_out[0]), 8'h71);
        chk("s3_tail_d15", int'(u_if.data_out[15]), 8'hBB);

        // Window straddling the wrap point
        do_reset();
        for (int i = 0; i < 120; i++) step(1'b1, 8'(i), 1'b0, 5'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 5'd16);
        step(1'b0, 8'h00, 1'b1, 5'd8);
        chk("s4_drained", int'(u_if.fifo_empty_out), 1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 5'd0);
        chk("s4_valid", int'(u_if.valid_bytes_out), 16);
        for (int i = 0; i < MAX_BYTES_OUT; i++) begin
            chk($sformatf("s4_d%0d", i), int'(u_if.data_out[i]), 8'hC0 + i);
        end
        step(1'b0, 8'h00, 1'b1, 5'd16);
        chk("s4_empty", int'(u_if.fifo_empty_out), 1);
        chk("s4_occ",   int'(u_if.occupancy), 0);
        chk("s4_err",   int'(u_if.error_out), 0);
        step(1'b1, 8'hEE, 1'b0, 5'd0);
        chk("s4_after_d0", int'(u_if.data_out[0]), 8'hEE);
        step(1'b0, 8'h00, 1'b1, 5'd0);
        chk("s4_num0_err", int'(u_if.error_out), 1);
        chk("s4_num0_occ", int'(u_if.occupancy), 1);

        // Simultaneous read and write on an empty FIFO
        do_reset();
        step(1'b1, 8'h5A, 1'b1, 5'd1);
        chk("s5_occ",   int'(u_if.occupancy), 1);
        chk("s5_valid", int'(u_if.valid_bytes_out), 1);
        chk("s5_d0",    int'(u_if.data_out[0]), 8'h5A);
        chk("s5_err",   int'(u_if.error_out), 1);

        // Asynchronous reset between edges with data stored
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 5'd0);
        chk("s6_pre_occ", int'(u_if.occupancy), 11);
        #2 reset = 1'b0;
        #1;
        chk_reset_state("s6_async");
        #2 reset = 1'b1;
        step(1'b1, 8'h77, 1'b0, 5'd0);
        chk("s6_d0",  int'(u_if.data_out[0]), 8'h77);
        chk("s6_occ", int'(u_if.occupancy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_multi_out.md
Name: fifo_multi_out

Overview:
- Byte-wide-in, multi-byte-out circular FIFO; the read-side counterpart of the compressor's multi-byte-in FIFO.
- Accepts at most one byte per cycle from a byte stream and presents a lookahead window of up to MAX_BYTES_OUT bytes.
- The consumer retires a variable number of window bytes (1..MAX_BYTES_OUT) per cycle.
- Feeds the LZRW1 match/literal stage, which peeks at several upcoming bytes and consumes 1 (literal) or up to 16 (copy) per cycle.

Parameters:
FIFO_SIZE, 128, depth in bytes; must be a power of 2 and >= MAX_BYTES_OUT
MAX_BYTES_OUT, 16, lookahead window width in bytes
(derived) ADDR_WIDTH = $clog2(FIFO_SIZE); CNT_WIDTH = $clog2(MAX_BYTES_OUT+1); OCC_WIDTH = $clog2(FIFO_SIZE+1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
data_in  input  8  byte to write
wr_en_in  input  1  write request for data_in this cycle
rd_en_in  input  1  consume request this cycle
num_bytes_in  input  CNT_WIDTH  bytes to consume when rd_en_in=1
data_out  output  8 x MAX_BYTES_OUT (unpacked)  data_out[i] = byte at front+i
valid_bytes_out  output  CNT_WIDTH  min(occupancy, MAX_BYTES_OUT)
fifo_empty_out  output  1  occupancy == 0
fifo_full_out  output  1  occupancy == FIFO_SIZE
occupancy  output  OCC_WIDTH  bytes currently stored
error_out  output  1  sticky; set on any rejected request

Behaviour:
- Reset (reset=0, asynchronous): front_ptr=0, back_ptr=0, occupancy=0, error_out=0.
- Reset-driven outputs: fifo_empty_out=1, fifo_full_out=0, valid_bytes_out=0, all data_out=0.
- Buffer contents need not be cleared.
- Reset mid-operation discards all stored bytes immediately; no partial outputs.
- Read acceptance: rd_acc = rd_en_in && num_bytes_in != 0 && num_bytes_in <= valid_bytes_out.
  - Otherwise the read is ignored, pointers are unchanged, and error_out sets if rd_en_in=1.
  - num_bytes_in = 0 with rd_en_in = 1 counts as an error.
- Write acceptance: wr_acc = wr_en_in && (!fifo_full_out || rd_acc).
  - A full FIFO accepts a write in the same cycle as an accepted read.
  - A rejected write drops the byte and sets error_out.
- Next-state updates:
  - On wr_acc: buffer[back_ptr] <= data_in; back_ptr <= back_ptr + 1 (mod FIFO_SIZE).
  - On rd_acc: front_ptr <= front_ptr + num_bytes_in (mod FIFO_SIZE); natural ADDR_WIDTH wrap.
  - occupancy <= occupancy + wr_acc - (rd_acc ? num_bytes_in : 0).
- Output timing and masking:
  - A byte written in cycle N appears on data_out no earlier than cycle N+1. There is no write-to-read bypass.
  - data_out[i] = buffer[(front_ptr + i) mod FIFO_SIZE] for i < valid_bytes_out, else 8'h00.
  - data_out is combinational from registered state only.
  - The window may straddle the wrap point (front_ptr near FIFO_SIZE-1). Indices wrap modulo FIFO_SIZE.
- Simultaneous read and write when occupancy=0: the read is rejected (valid_bytes_out=0) and the write is accepted.
- error_out clears only on reset.
- Assertions: occupancy <= FIFO_SIZE at every edge. Flags stay consistent with occupancy.

Test Plan:
1. Reset, then write 0x01..0x05 on 5 cycles -> valid_bytes_out=5, data_out[0..4]=01..05, data_out[5..15]=00, occupancy=5, error_out=0.
2. From scenario 1: rd_en_in=1, num_bytes_in=3 -> next cycle data_out[0]=04, data_out[1]=05, valid_bytes_out=2. Then num_bytes_in=3 again -> read ignored, error_out=1, occupancy stays 2.
3. Fill 128 bytes (0x00..0x7F) -> fifo_full_out=1, valid_bytes_out=16. A write of 0xAA alone -> dropped, error_out=1. Write 0xBB together with read num=1 -> occupancy stays 128, and the byte at front+127 is 0xBB.
4. Wrap: advance front_ptr to 120 via write/consume, hold 16 bytes -> data_out[0..7] from addresses 120..127 and data_out[8..15] from 0..7, in order. Consume 16 -> front_ptr=8, empty=1.
5. Empty FIFO, wr_en_in=1 (0x5A) and rd_en_in=1, num=1 in the same cycle -> write accepted, read rejected, occupancy=1, data_out[0]=5A next cycle, error_out=1.
6. With 10 bytes stored, pulse reset low between clock edges -> all outputs return to reset values immediately, and a subsequent write of 0x77 reads back at data_out[0].
